// File: rtl/dmi_if.sv
// DMI request/response channel between the debug transport (initiator) and the debug module.
interface dmi_if #(
    parameter int unsigned AddressWidth = 7,
    parameter int unsigned DataWidth    = 32
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic [AddressWidth-1:0] req_addr;
    logic [DataWidth-1:0]    req_data;
    logic [1:0]              req_op;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DataWidth-1:0]    rsp_data;
    logic [1:0]              rsp_op;

    modport master (
        output req_valid, req_addr, req_data, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_op
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_op
    );
endinterface

// File: rtl/dmi_uart_dtm.sv
// UART debug transport: decodes binary request frames from the host, issues one DMI
// transaction per frame and returns the status/data as a UART response frame.
module dmi_uart_dtm #(
    parameter int unsigned ClockHz      = 50000000,
    parameter int unsigned BaudRate     = 115200,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 7,
    parameter int unsigned TimeoutBits  = 64
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  uart_rx,
    output logic  uart_tx,
    dmi_if.master dmi
);
    localparam int unsigned Div           = (ClockHz + BaudRate / 2) / BaudRate;
    localparam int unsigned Half          = Div / 2;
    localparam int unsigned Nb            = DataWidth / 8;
    localparam int unsigned FrameBytes    = Nb + 2;
    localparam int unsigned TimeoutCycles = TimeoutBits * Div;
    localparam int unsigned DivW          = $clog2(Div);
    localparam int unsigned TmoW          = $clog2(TimeoutCycles + 1);
    localparam int unsigned CntW          = $clog2(FrameBytes + 1);

    localparam logic [DivW-1:0] DivMax  = DivW'(Div - 1);
    localparam logic [DivW-1:0] HalfMax = DivW'(Half - 1);
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(TimeoutCycles);
    localparam logic [CntW-1:0] LastCnt = CntW'(FrameBytes - 1);
    localparam logic [CntW-1:0] TxLast  = CntW'(Nb);

    localparam logic [1:0] StRxFrame = 2'd0;
    localparam logic [1:0] StIssue   = 2'd1;
    localparam logic [1:0] StWaitRsp = 2'd2;
    localparam logic [1:0] StTxFrame = 2'd3;

    // ---------------- UART receiver ----------------
    logic [1:0]      rx_sync_q;
    logic            rx_prev_q;
    logic            rx_busy_q;
    logic [3:0]      rx_bit_q;
    logic [DivW-1:0] rx_div_q;
    logic [7:0]      rx_shift_q;
    logic            rx_s;
    logic            rx_done;
    logic            rx_ok;

    assign rx_s    = rx_sync_q[1];
    // Stop-bit sample strobe; rx_ok qualifies it with a valid (high) stop bit.
    assign rx_done = rx_busy_q && (rx_bit_q == 4'd9) && (rx_div_q == DivMax);
    assign rx_ok   = rx_done && rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_bit_q   <= '0;
            rx_div_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], uart_rx};
            rx_prev_q <= rx_s;
            if (!rx_busy_q) begin
                if (rx_prev_q && !rx_s) begin
                    rx_busy_q <= 1'b1;
                    rx_bit_q  <= '0;
                    rx_div_q  <= '0;
                end
            end else if (rx_bit_q == 4'd0) begin
                if (rx_div_q == HalfMax) begin
                    rx_div_q <= '0;
                    if (rx_s) begin
                        rx_busy_q <= 1'b0;
                    end else begin
                        rx_bit_q <= 4'd1;
                    end
                end else begin
                    rx_div_q <= rx_div_q + 1'b1;
                end
            end else if (rx_div_q == DivMax) begin
                rx_div_q <= '0;
                if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                end else begin
                    rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 1'b1;
                end
            end else begin
                rx_div_q <= rx_div_q + 1'b1;
            end
        end
    end

    // ---------------- Frame handling, DMI and UART transmitter ----------------
    logic [1:0]              state_q;
    logic [CntW-1:0]         byte_cnt_q;
    logic [TmoW-1:0]         tmo_q;
    logic [1:0]              op_q;
    logic [AddressWidth-1:0] addr_q;
    logic [DataWidth-1:0]    data_q;
    logic [DataWidth-1:0]    data_shifted;
    logic                    req_valid_q;
    logic                    rsp_ready_q;
    logic [AddressWidth-1:0] req_addr_q;
    logic [DataWidth-1:0]    req_data_q;
    logic [1:0]              req_op_q;
    logic [1:0]              status_q;
    logic [DataWidth-1:0]    tx_data_q;
    logic                    tx_q;
    logic                    tx_started_q;
    logic [8:0]              tx_sh_q;
    logic [3:0]              tx_bit_q;
    logic [DivW-1:0]         tx_div_q;
    logic [CntW-1:0]         tx_idx_q;

    // Data bytes arrive LSB first, so each new byte enters at the top of the shift register.
    assign data_shifted = (data_q >> 8) | (DataWidth'(rx_shift_q) << (DataWidth - 8));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRxFrame;
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            req_valid_q  <= 1'b0;
            rsp_ready_q  <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_op_q     <= '0;
            status_q     <= '0;
            tx_data_q    <= '0;
            tx_q         <= 1'b1;
            tx_started_q <= 1'b0;
            tx_sh_q      <= '1;
            tx_bit_q     <= '0;
            tx_div_q     <= '0;
            tx_idx_q     <= '0;
        end else begin
            unique case (state_q)
                StRxFrame: begin
                    if (rx_done && !rx_ok) begin
                        byte_cnt_q <= '0;
                        tmo_q      <= '0;
                    end else if (rx_ok) begin
                        tmo_q <= '0;
                        if (byte_cnt_q == '0) begin
                            op_q <= rx_shift_q[1:0];
                        end else if (byte_cnt_q == CntW'(1)) begin
                            addr_q <= rx_shift_q[AddressWidth-1:0];
                        end else begin
                            data_q <= data_shifted;
                        end
                        if (byte_cnt_q == LastCnt) begin
                            byte_cnt_q <= '0;
                            if (op_q == 2'b11) begin
                                status_q     <= 2'b10;
                                tx_data_q    <= '0;
                                tx_started_q <= 1'b0;
                                state_q      <= StTxFrame;
                            end else begin
                                req_op_q    <= op_q;
                                req_addr_q  <= addr_q;
                                req_data_q  <= data_shifted;
                                req_valid_q <= 1'b1;
                                state_q     <= StIssue;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end else if (byte_cnt_q == '0) begin
                        tmo_q <= '0;
                    end else if (!rx_busy_q) begin
                        // Only line-idle time between bytes counts toward the timeout.
                        if (tmo_q == TmoMax) begin
                            byte_cnt_q <= '0;
                            tmo_q      <= '0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (dmi.req_ready) begin
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        state_q     <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    if (dmi.rsp_valid) begin
                        rsp_ready_q  <= 1'b0;
                        status_q     <= dmi.rsp_op;
                        tx_data_q    <= dmi.rsp_data;
                        tx_started_q <= 1'b0;
                        state_q      <= StTxFrame;
                    end
                end
                StTxFrame: begin
                    if (!tx_started_q) begin
                        tx_started_q <= 1'b1;
                        tx_q         <= 1'b0;
                        tx_sh_q      <= {1'b1, 6'b0, status_q};
                        tx_bit_q     <= '0;
                        tx_div_q     <= '0;
                        tx_idx_q     <= '0;
                    end else if (tx_div_q != DivMax) begin
                        tx_div_q <= tx_div_q + 1'b1;
                    end else begin
                        tx_div_q <= '0;
                        if (tx_bit_q == 4'd9) begin
                            if (tx_idx_q == TxLast) begin
                                tx_started_q <= 1'b0;
                                state_q      <= StRxFrame;
                            end else begin
                                tx_idx_q  <= tx_idx_q + 1'b1;
                                tx_q      <= 1'b0;
                                tx_sh_q   <= {1'b1, tx_data_q[7:0]};
                                tx_data_q <= tx_data_q >> 8;
                                tx_bit_q  <= '0;
                            end
                        end else begin
                            tx_q     <= tx_sh_q[0];
                            tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
                            tx_bit_q <= tx_bit_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign uart_tx       = tx_q;
    assign dmi.req_valid = req_valid_q;
    assign dmi.req_addr  = req_addr_q;
    assign dmi.req_data  = req_data_q;
    assign dmi.req_op    = req_op_q;
    assign dmi.rsp_ready = rsp_ready_q;
endmodule

// File: tb/tb_dmi_uart_dtm.sv
// Directed bench for dmi_uart_dtm: host UART driver, DMI responder model and TX decoder,
// with expected requests and response bytes held in scoreboard queues.
module tb_dmi_uart_dtm;
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;

    dmi_if #(.AddressWidth(7), .DataWidth(32)) dmi ();

    dmi_uart_dtm #(
        .ClockHz     (1600000),
        .BaudRate    (100000),
        .DataWidth   (32),
        .AddressWidth(7),
        .TimeoutBits (64)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .dmi    (dmi)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  rsp_op;
        logic [31:0] rsp_data;
    } req_t;

    req_t       exp_req[$];
    logic [7:0] exp_tx[$];
    int n_tests   = 0;
    int n_fail    = 0;
    int hs_cnt    = 0;
    int exp_hs    = 0;
    int ready_dly = 0;
    int rsp_dly   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input logic [1:0] st, input logic [31:0] d);
        exp_tx.push_back({6'b0, st});
        for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
    endtask

    task automatic expect_txn(input logic [1:0] op, input logic [6:0] addr,
                              input logic [31:0] data, input logic [1:0] rsp_op,
                              input logic [31:0] rsp_data);
        req_t e;
        e.op = op;
        e.addr = addr;
        e.data = data;
        e.rsp_op = rsp_op;
        e.rsp_data = rsp_data;
        exp_req.push_back(e);
        exp_hs++;
        expect_rsp(rsp_op, rsp_data);
    endtask

    // One 8N1 character, 16 clocks per bit; optional check of request latency on the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit chk_lat);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = stop_bit;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (chk_lat && k == 1) chk("req_valid_before_stop", dmi.req_valid, 1'b0);
            if (chk_lat && k == 14) chk("req_valid_after_stop", dmi.req_valid, 1'b1);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [47:0] f, input bit chk_lat);
        for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8], 1'b1, chk_lat && (i == 5));
    endtask

    task automatic wait_drain(input int budget, input int tail);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_req.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_tx.size() + exp_req.size(), 0);
        repeat (tail) @(negedge clk);
    endtask

    // DMI responder model
    initial begin
        req_t e;
        bit   aborted;
        dmi.req_ready = 1'b0;
        dmi.rsp_valid = 1'b0;
        dmi.rsp_op    = 2'b00;
        dmi.rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && dmi.req_valid === 1'b1) begin
                chk("req_expected", exp_req.size() != 0, 1'b1);
                if (exp_req.size() != 0) e = exp_req.pop_front();
                else e = '0;
                chk("req_op", dmi.req_op, e.op);
                chk("req_addr", dmi.req_addr, e.addr);
                chk("req_data", dmi.req_data, e.data);
                aborted = 1'b0;
                for (int i = 0; i < ready_dly; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    chk("req_valid_hold", dmi.req_valid, 1'b1);
                    chk("req_data_hold", dmi.req_data, e.data);
                end
                if (!aborted) begin
                    dmi.req_ready = 1'b1;
                    @(negedge clk);
                    dmi.req_ready = 1'b0;
                    hs_cnt++;
                    chk("req_valid_drop", dmi.req_valid, 1'b0);
                    chk("rsp_ready_rise", dmi.rsp_ready, 1'b1);
                    repeat (rsp_dly) @(negedge clk);
                    dmi.rsp_valid = 1'b1;
                    dmi.rsp_op    = e.rsp_op;
                    dmi.rsp_data  = e.rsp_data;
                    @(negedge clk);
                    dmi.rsp_valid = 1'b0;
                    chk("rsp_ready_drop", dmi.rsp_ready, 1'b0);
                end
            end
        end
    end

    // UART TX decoder
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                logic [7:0] b;
                repeat (7) @(negedge clk);
                chk("tx_start_bit", uart_tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (16) @(negedge clk);
                chk("tx_stop_bit", uart_tx, 1'b1);
                chk("tx_expected", exp_tx.size() != 0, 1'b1);
                if (exp_tx.size() != 0) chk("tx_byte", b, exp_tx.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1'b1);
        chk("rst_req_valid", dmi.req_valid, 1'b0);
        chk("rst_rsp_ready", dmi.rsp_ready, 1'b0);
        chk("rst_req_addr", dmi.req_addr, 7'h00);
        chk("rst_req_data", dmi.req_data, 32'h0);
        chk("rst_req_op", dmi.req_op, 2'b00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Read
        ready_dly = 5;
        rsp_dly   = 3;
        expect_txn(2'b01, 7'h11, 32'h0, 2'b00, 32'h0000_0C82);
        send_frame(48'h01_11_00_00_00_00, 1'b1);
        wait_drain(4000, 20);
        chk("hs_read", hs_cnt, exp_hs);

        // Write with backpressure
        ready_dly = 10;
        rsp_dly   = 2;
        expect_txn(2'b10, 7'h10, 32'h8000_0001, 2'b00, 32'h0);
        send_frame(48'h02_10_01_00_00_80, 1'b0);
        wait_drain(4000, 20);
        chk("hs_write", hs_cnt, exp_hs);

        // Reserved op: local status, no DMI traffic
        expect_rsp(2'b10, 32'h0);
        send_frame(48'h03_04_00_00_00_00, 1'b0);
        wait_drain(4000, 20);
        chk("hs_reserved", hs_cnt, exp_hs);

        // Framing error on byte 2, then a clean read
        ready_dly = 1;
        rsp_dly   = 1;
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h20, 1'b1, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        repeat (32) @(negedge clk);
        expect_txn(2'b01, 7'h07, 32'h0, 2'b00, 32'hDEAD_BEEF);
        send_frame(48'h01_07_00_00_00_00, 1'b0);
        wait_drain(4000, 20);
        chk("hs_framing", hs_cnt, exp_hs);

        // Inter-byte timeout drops the partial frame
        send_byte(8'h02, 1'b1, 1'b0);
        send_byte(8'h10, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        repeat (65 * 16) @(negedge clk);
        expect_txn(2'b10, 7'h05, 32'h1234_5678, 2'b00, 32'h0);
        send_frame(48'h02_05_78_56_34_12, 1'b0);
        wait_drain(4000, 20);
        chk("hs_timeout", hs_cnt, exp_hs);

        // Bytes arriving during WAIT_RSP are dropped
        ready_dly = 0;
        rsp_dly   = 400;
        expect_txn(2'b01, 7'h22, 32'h0, 2'b00, 32'h55AA_0033);
        send_frame(48'h01_22_00_00_00_00, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        wait_drain(4000, 12);
        rsp_dly = 1;
        expect_txn(2'b10, 7'h33, 32'hCAFE_F00D, 2'b00, 32'h0);
        send_frame(48'h02_33_0D_F0_FE_CA, 1'b0);
        wait_drain(4000, 20);
        chk("hs_busy", hs_cnt, exp_hs);

        // Reset while the request is pending
        ready_dly = 1000;
        exp_req.push_back('{op: 2'b01, addr: 7'h01, data: 32'h0, rsp_op: 2'b00, rsp_data: 32'h0});
        send_frame(48'h01_01_00_00_00_00, 1'b0);
        n = 0;
        while (dmi.req_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_issue_req_seen", dmi.req_valid, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req_valid", dmi.req_valid, 1'b0);
        chk("async_rst_rsp_ready", dmi.rsp_ready, 1'b0);
        chk("async_rst_uart_tx", uart_tx, 1'b1);
        chk("async_rst_req_op", dmi.req_op, 2'b00);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("idle_after_rst", dmi.req_valid, 1'b0);
        chk("hs_after_rst", hs_cnt, exp_hs);
        ready_dly = 2;
        expect_txn(2'b01, 7'h3F, 32'h0, 2'b10, 32'hA5A5_0001);
        send_frame(48'h01_3F_00_00_00_00, 1'b0);
        wait_drain(4000, 20);
        chk("hs_post_rst", hs_cnt, exp_hs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
